// File: rtl/mp64_sram_ctl.sv
// mp64_sram_ctl: initiator-side controller for a synchronous single-port SRAM.
// Turns a valid/ready request stream into SRAM port cycles and returns read
// data in order through a credit-protected response FIFO. A fill engine can
// sweep the whole array with a constant pattern.
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid && ready are both high; the initiator holds valid and payload
// stable until that edge; ready never depends on valid.
module mp64_sram_ctl #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 512,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              init_start,
    input  logic [DATA_W-1:0] init_data,
    output logic              init_done,
    output logic              busy,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(RSP_DEPTH);
    localparam logic [CW-1:0]   FIFO_FULL  = CW'(RSP_DEPTH);
    localparam logic [ADDR_W:0] SWEEP_LAST = {1'b0, {ADDR_W{1'b1}}};

    // Parameter legality is checked at elaboration time.
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("mp64_sram_ctl: RD_LAT must be 1 or 2");
    end
    if (RSP_DEPTH < RD_LAT + 1 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_rsp_depth
        $error("mp64_sram_ctl: RSP_DEPTH must be a power of two and >= RD_LAT+1");
    end

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_INIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   sweep_q, sweep_d;
    logic              done_q, done_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     fifo_cnt_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [RD_LAT-1:0] rd_tag_q;
    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
    logic [CW:0]       credit_sum;
    logic              issue, rd_issue, push, pop;

    // Credits count reads in the SRAM pipeline plus responses parked in the
    // FIFO; both are registered, so a pop frees its credit one cycle later.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign req_ready  = rst_n && (state_q == S_RUN) && (credit_sum < CREDIT_MAX);
    assign issue      = req_valid && req_ready;
    assign rd_issue   = issue && !req_we;
    assign push       = rd_tag_q[RD_LAT-1];
    assign pop        = rsp_valid && rsp_ready;
    assign inflight_d = inflight_q + CW'(rd_issue) - CW'(push);

    assign rsp_valid  = (fifo_cnt_q != '0);
    assign rsp_data   = fifo_mem[rd_ptr_q];
    assign init_done  = done_q;
    assign busy       = (state_q != S_RUN);

    // Next-state logic and the combinational SRAM port drive.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        done_d     = 1'b0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
        case (state_q)
            S_RUN: begin
                sram_ce = issue;
                sram_we = issue && req_we;
                // A read issued this cycle must land before the sweep starts.
                if (init_start) begin
                    state_d = (inflight_d == '0) ? S_INIT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                sram_ce    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = sweep_q[ADDR_W-1:0];
                sram_wdata = init_data;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = S_RUN;
                    sweep_d = '0;
                    done_d  = 1'b1;
                end else begin
                    sweep_d = sweep_q + (ADDR_W + 1)'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
        // Reset is synchronous, so the port is also gated directly while it is held.
        if (!rst_n) begin
            sram_ce = 1'b0;
            sram_we = 1'b0;
        end
    end

    // State, sweep counter, done pulse, read tags and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            sweep_q    <= '0;
            done_q     <= 1'b0;
            inflight_q <= '0;
            rd_tag_q   <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            done_q      <= done_d;
            inflight_q  <= inflight_d;
            rd_tag_q[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_tag_q[i] <= rd_tag_q[i-1];
            end
            fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Response storage captures SRAM read data when its tag emerges.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sram_rdata;
        end
    end

    // The credit rule must make a push into a full FIFO unreachable.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_cnt_q == FIFO_FULL));

endmodule

// File: tb/tb_mp64_sram_ctl.sv
// Self-checking bench for mp64_sram_ctl: an SRAM model with configurable read
// latency, a reference memory plus expected-response queue, and scenario tasks.
module tb_mp64_sram_ctl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int RSPD  = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          init_start, init_done, busy;
    logic [DW-1:0] init_data;
    logic          sram_ce, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    int n_cmp       = 0;
    int n_bad       = 0;
    int n_rsp       = 0;
    int cyc         = 0;
    int last_rd_cyc = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_w;
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] rd_pipe [LAT];

    mp64_sram_ctl #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .RSP_DEPTH(RSPD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_start(init_start), .init_data(init_data), .init_done(init_done),
        .busy(busy),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model (RD_LAT-cycle read pipeline) ----------------
    always @(posedge clk) begin
        if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;
        rd_pipe[0] <= sram_mem[sram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[LAT-1];

    // ---------------- scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rsp_valid && rsp_ready) begin
                    n_rsp++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL rsp_extra: got %h with no read outstanding", rsp_data);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (rsp_data !== exp_w) begin
                            n_bad++;
                            $display("FAIL rsp_data: got %h expected %h", rsp_data, exp_w);
                        end
                    end
                end
                if (req_valid && req_ready) begin
                    if (req_we) ref_mem[req_addr] = req_wdata;
                    else begin
                        exp_q.push_back(ref_mem[req_addr]);
                        last_rd_cyc = cyc;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic ok;
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            tick();
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL send_timeout: req_ready=0 for 100 cycles, required 1 (addr %0d)", a);
        end
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic fill_all();
        for (int a = 0; a < DEPTH; a++) send(1'b1, AW'(a), $urandom());
    endtask

    task automatic readback(input int skip);
        for (int a = 0; a < DEPTH; a++) if (a != skip) send(1'b0, AW'(a), '0);
        drain();
    endtask

    // Observe a fill sweep started in the previous cycle.
    task automatic watch_sweep(input logic [DW-1:0] pat, input int land_cyc);
        int nwr, first_wr, last_wr, done_cyc, ndone, wr_bad, gap, busy_bad;
        nwr = 0; first_wr = -1; last_wr = -1; done_cyc = -1; ndone = 0;
        wr_bad = 0; gap = 0; busy_bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (init_done) begin ndone++; done_cyc = cyc; end
            if (sram_ce) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (!sram_we || sram_addr !== AW'(nwr) || sram_wdata !== pat) wr_bad++;
                nwr++;
            end else if (first_wr >= 0 && nwr < DEPTH) gap++;
            if (nwr < DEPTH && !busy) busy_bad++;
            tick();
        end
        n_cmp++; if (nwr != DEPTH) begin n_bad++; $display("FAIL sweep_writes: got %0d writes, required %0d", nwr, DEPTH); end
        n_cmp++; if (wr_bad != 0) begin n_bad++; $display("FAIL sweep_content: %0d bad addr/data/we cycles, required 0", wr_bad); end
        n_cmp++; if (gap != 0) begin n_bad++; $display("FAIL sweep_gap: %0d idle cycles inside sweep, required 0", gap); end
        n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL sweep_busy: busy low %0d cycles, required 0", busy_bad); end
        n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL init_done_count: got %0d pulses, required 1", ndone); end
        n_cmp++; if (done_cyc != last_wr + 1) begin n_bad++; $display("FAIL init_done_time: got cycle %0d, required %0d", done_cyc, last_wr + 1); end
        n_cmp++; if (first_wr < land_cyc + LAT + 1) begin n_bad++; $display("FAIL sweep_start: first write cycle %0d, required >= %0d", first_wr, land_cyc + LAT + 1); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bad;
        bad = 0;
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = '0; req_wdata = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sram_ce || sram_we) bad++;
            tick();
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL reset_sram_ce: ce/we high %0d cycles in reset, required 0", bad); end
        req_valid = 1'b0; rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b required 0", init_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        tick();
    endtask

    task automatic test_write_read();
        int n0, k;
        logic found;
        rsp_ready = 1'b1;
        send(1'b1, AW'(3), DW'(32'hA5));
        n0 = n_rsp;
        send(1'b0, AW'(3), '0);
        found = 1'b0; k = 0;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1; k = i;
                n_cmp++;
                if (rsp_data !== DW'(32'hA5)) begin n_bad++; $display("FAIL wr_rd_data: got %h required %h", rsp_data, 32'hA5); end
            end
            tick();
        end
        n_cmp++; if (k != LAT + 1) begin n_bad++; $display("FAIL wr_rd_latency: got %0d cycles required %0d", k, LAT + 1); end
        repeat (5) tick();
        n_cmp++; if (n_rsp - n0 != 1) begin n_bad++; $display("FAIL wr_rd_count: got %0d responses required 1", n_rsp - n0); end
    endtask

    task automatic test_credit();
        int acc, n0;
        acc = 0; n0 = n_rsp;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'($urandom_range(0, DEPTH - 1));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready) acc++;
            tick();
            if (acc > 0 && req_ready === 1'b0) ;
            req_addr = AW'($urandom_range(0, DEPTH - 1));
        end
        req_valid = 1'b0;
        n_cmp++; if (acc != RSPD) begin n_bad++; $display("FAIL credit_accepts: got %0d required %0d", acc, RSPD); end
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL credit_stall: req_ready %b required 0", req_ready); end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL credit_pop_cycle: req_ready %b required 0", req_ready); end
        tick();
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL credit_return: req_ready %b required 1", req_ready); end
        tick();
        drain();
        n_cmp++; if (n_rsp - n0 != RSPD) begin n_bad++; $display("FAIL credit_rsp_count: got %0d required %0d", n_rsp - n0, RSPD); end
    endtask

    task automatic test_stream();
        int stalls, first, last, cnt;
        fill_all();
        stalls = 0; first = -1; last = -1; cnt = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 16 + LAT + 12; c++) begin
            if (c < 16) begin req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(c); end
            else req_valid = 1'b0;
            @(negedge clk);
            if (c < 16 && !req_ready) stalls++;
            if (rsp_valid) begin
                if (first < 0) first = c;
                last = c; cnt++;
            end
            tick();
        end
        req_valid = 1'b0;
        n_cmp++; if (stalls != 0) begin n_bad++; $display("FAIL stream_stalls: got %0d required 0", stalls); end
        n_cmp++; if (first != LAT + 1) begin n_bad++; $display("FAIL stream_first: got cycle %0d required %0d", first, LAT + 1); end
        n_cmp++; if (cnt != 16 || last - first != 15) begin n_bad++; $display("FAIL stream_contiguous: got %0d valid over span %0d, required 16 over 15", cnt, last - first); end
        drain();
    endtask

    task automatic test_random();
        int n0, n_rd;
        logic acc;
        n0 = n_rsp; n_rd = 0;
        for (int c = 0; c < 300; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req_valid && $urandom_range(0, 9) < 7) begin
                req_valid = 1'b1;
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = AW'($urandom_range(0, DEPTH - 1));
                req_wdata = $urandom();
            end
            @(negedge clk);
            acc = req_valid && req_ready;
            tick();
            if (acc) begin
                if (!req_we) n_rd++;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        drain();
        n_cmp++; if (n_rsp - n0 != n_rd) begin n_bad++; $display("FAIL random_rsp_count: got %0d required %0d", n_rsp - n0, n_rd); end
    endtask

    task automatic test_init_drain();
        rsp_ready = 1'b1;
        send(1'b0, AW'(1), '0);
        send(1'b0, AW'(2), '0);
        init_data = DW'(32'hDEAD); init_start = 1'b1;
        tick();
        init_start = 1'b0;
        watch_sweep(DW'(32'hDEAD), last_rd_cyc);
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = DW'(32'hDEAD);
        readback(-1);
    endtask

    task automatic test_start_with_read();
        int n0;
        logic [DW-1:0] pat;
        pat = $urandom();
        drain();
        n0 = n_rsp;
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(5);
        init_data = pat; init_start = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL start_read_accept: req_ready %b required 1", req_ready); end
        tick();
        req_valid = 1'b0; init_start = 1'b0;
        watch_sweep(pat, last_rd_cyc);
        n_cmp++; if (n_rsp - n0 != 1) begin n_bad++; $display("FAIL start_read_rsp: got %0d responses required 1", n_rsp - n0); end
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = pat;
        readback(-1);
    endtask

    task automatic test_reset_mid_sweep();
        logic [DW-1:0] pat;
        logic found;
        int dones, ce_bad;
        fill_all();
        drain();
        pat = $urandom();
        found = 1'b0; dones = 0; ce_bad = 0;
        init_data = pat; init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (init_done) dones++;
            if (sram_ce && sram_we && sram_addr == AW'(6)) found = 1'b1;
            tick();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL abort_reach: sweep write to addr 6 seen=%b required 1", found); end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sram_ce || sram_we) ce_bad++;
            if (init_done) dones++;
            tick();
        end
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b required 0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_rsp_valid: got %b required 0", rsp_valid); end
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (init_done) dones++;
            if (sram_ce) ce_bad++;
            tick();
        end
        n_cmp++; if (ce_bad != 0) begin n_bad++; $display("FAIL abort_sram_ce: ce high %0d cycles, required 0", ce_bad); end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_init_done: got %0d pulses required 0", dones); end
        for (int a = 0; a < 7; a++) ref_mem[a] = pat;
        readback(7);
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; init_start = 1'b0; init_data = '0;
        tick();
        test_reset();
        test_write_read();
        fill_all();
        test_credit();
        test_stream();
        test_random();
        test_init_drain();
        test_start_with_read();
        test_reset_mid_sweep();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL final_queue: %0d expected responses left, required 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mp64_sram_ctl.md
Name: mp64_sram_ctl

Overview:
Initiator-side controller for a synchronous single-port SRAM macro (ce/we/addr/wdata/rdata port, 1- or 2-cycle read latency). It converts a valid/ready request stream into SRAM port cycles. It also tracks in-flight reads and returns read data through a credit-protected response FIFO, so responses are never lost under backpressure. A built-in fill engine sweeps the whole array with a constant pattern for boot-time or secure clearing.

Parameters:
ADDR_W, 14, SRAM address bits; DEPTH = 2^ADDR_W.
DATA_W, 512, data width in bits.
RD_LAT, 1, SRAM read latency in cycles. Legal values are 1 (no output register) and 2 (output register). Any other value is an elaboration error.
RSP_DEPTH, 4, response FIFO entries. Must be >= RD_LAT+1 and a power of two.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  DATA_W  read data, in request order
init_start  in  1  one-cycle pulse that starts the fill sweep
init_data  in  DATA_W  fill pattern, sampled each sweep cycle
init_done  out  1  one-cycle pulse after the last fill write
busy  out  1  high whenever the state is not S_RUN
sram_ce  out  1  SRAM chip enable
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the ce cycle

Behaviour:
- Reset state:
  - state = S_RUN; FIFO empty; read-tracking pipeline cleared.
  - rsp_valid = 0, init_done = 0, busy = 0.
  - sram_ce = 0 and sram_we = 0 while rst_n = 0.
- Reset mid-operation:
  - In-flight reads and queued responses are discarded.
  - A running sweep is aborted with no init_done pulse.
  - SRAM contents are untouched.
- SRAM port drive:
  - The SRAM port is combinational from the accepted handshake, so the SRAM samples in the same cycle.
  - S_RUN: sram_ce = req_valid && req_ready; sram_we = sram_ce && req_we; sram_addr and sram_wdata come from req_*.
  - S_INIT: sram_ce = sram_we = 1; sram_addr = sweep counter; sram_wdata = init_data.
  - S_DRAIN: sram_ce = 0.
- Credits:
  - inflight = reads issued whose data has not yet been pushed into the FIFO.
  - req_ready = (state == S_RUN) && (inflight + fifo_count < RSP_DEPTH).
  - req_ready does not depend on req_valid or req_we; writes also wait for a credit.
  - A pop in the same cycle does not free a credit until the next cycle, which keeps the credit path registered.
- Read pipeline:
  - An RD_LAT-deep valid shift register tags each issued read.
  - On the cycle the tag emerges, sram_rdata is pushed into the FIFO.
  - Read accepted in cycle T → rsp_valid first asserts in cycle T+RD_LAT+1, with rsp_data from the FIFO storage register.
  - Back-to-back reads with rsp_ready held high give one response per cycle.
  - Responses are delivered in order; write-then-read to the same address returns the new data.
- FIFO:
  - rsp_valid = (fifo_count != 0); pop on rsp_valid && rsp_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - The credit rule makes overflow impossible; push-while-full is an assertion failure.
- State machine (S_RUN, S_DRAIN, S_INIT):
  - S_RUN, init_start = 1: go to S_INIT if inflight == 0 after this cycle's issue, otherwise go to S_DRAIN. A request handshaking in that same cycle is still accepted and completes normally.
  - S_DRAIN: wait until inflight == 0, then go to S_INIT. The FIFO need not be empty; pending responses may still drain via rsp_ready.
  - S_INIT: the sweep counter starts at 0 and writes one address per cycle. At DEPTH-1 the block asserts init_done for one cycle (the cycle after the last write), returns to S_RUN and clears the counter.
  - init_start outside S_RUN is ignored.
- Widths:
  - The sweep counter is ADDR_W+1 bits wide, so it terminates without wrap-around.
  - inflight and fifo_count are each $clog2(RSP_DEPTH)+1 bits wide.

Test Plan:
1. RD_LAT=1: write 0xA5 (zero-extended) to addr 3, then read addr 3 → exactly one rsp with rsp_data=0xA5, rsp_valid asserting 2 cycles after the read handshake.
2. RD_LAT=2, RSP_DEPTH=4, rsp_ready=0: issue reads continuously → exactly 4 accepted, then req_ready=0. Release rsp_ready → 4 in-order responses, and req_ready re-asserts the cycle after the first pop.
3. Streaming reads of addrs 0..15 with rsp_ready=1 → 16 responses in address order; after the initial latency, rsp_valid stays high every cycle.
4. ADDR_W=4: init_start with init_data=0xDEAD while 2 reads are in flight → S_DRAIN until both land, then 16 consecutive writes to addrs 0..15, a 1-cycle init_done pulse, and busy high throughout. Readback of all 16 addresses returns 0xDEAD.
5. Simultaneous init_start and an accepted read in the same cycle → the read response is delivered, and the sweep starts only after it has landed.
6. Assert rst_n=0 mid-sweep at addr 7 → no init_done pulse, and sram_ce=0 while reset is held. After reset: busy=0, rsp_valid=0, addrs 0..6 hold the pattern and addrs 8..15 keep their old data.
